// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// sequencer states and operation latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W   = 4;

  // Reserved encoding 7 behaves exactly like NONE.
  function automatic logic is_real_op(input logic [2:0] op);
    return (op != OP_NONE) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product / quotient / remainder generator.
// HI carries the product's upper word or the remainder, LO the lower word or quotient.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] safe_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] sgn_q;
  logic [31:0] sgn_r;
  logic [31:0] uns_q;
  logic [31:0] uns_r;
  logic        b_zero;
  logic        div_ovf;

  assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u  = {32'd0, a} * {32'd0, b};
  assign b_zero  = (b == 32'd0);
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // A zero divisor is replaced by 1 so the dividers never see it; that case is overridden below.
  assign safe_b = b_zero ? 32'd1 : b;
  assign abs_a  = a[31] ? -a : a;
  assign abs_b  = b_zero ? 32'd1 : (b[31] ? -b : b);

  // Signed division works on magnitudes: quotient truncates toward zero, remainder follows the dividend.
  assign mag_q = abs_a / abs_b;
  assign mag_r = abs_a % abs_b;
  assign sgn_q = (a[31] ^ b[31]) ? -mag_q : mag_q;
  assign sgn_r = a[31] ? -mag_r : mag_r;
  assign uns_q = a / safe_b;
  assign uns_r = a % safe_b;

  // Select the result pair for the requested operation, including divide special cases.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op_e'(op))
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = sgn_r;
          res_lo = sgn_q;
        end
      end
      OP_DIVU: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = uns_r;
          res_lo = uns_q;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning the architectural HI/LO registers.
// Results are computed at issue, held pending, and committed after a fixed latency.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  mdu_state_e       state;
  mdu_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      hi_next;
  logic [31:0]      lo_next;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [31:0]      pend_hi_next;
  logic [31:0]      pend_lo_next;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             accept;

  mdu_arith u_arith (
    .op     (md_op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign accept = start && !flush && (state == ST_IDLE) && is_real_op(md_op);

  // Next-state, counter, HI/LO and status decode; a flush never touches work already in flight.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (md_op_e'(md_op))
            OP_MULT, OP_MULTU: begin
              pend_hi_next = res_hi;
              pend_lo_next = res_lo;
              cnt_next     = MUL_CNT;
              state_next   = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_next = res_hi;
              pend_lo_next = res_lo;
              cnt_next     = DIV_CNT;
              state_next   = ST_DIV;
            end
            OP_MTHI: hi_next = rs_val;
            OP_MTLO: lo_next = rs_val;
            default: state_next = ST_IDLE;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        busy = 1'b1;
        if (cnt == '0) begin
          done       = 1'b1;
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation without committing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
    end
  end

endmodule
